vote_checker: RTL

VOTE_CHECKER -- requirements
Module: vote_checker

---
 rtl/vote_pkg.sv | 36 +++
 rtl/vote_ref.sv | 18 +
 rtl/vote_checker.sv | 219 +++++++++++++++++++++
 3 files changed

// File: rtl/vote_pkg.sv
// -----------------------------------------------------------------------------
// vote_pkg
// Shared definitions for the 3-of-5 voter checker.
//   - vote_state_e   : checker FSM states (HALT only reachable when the
//                      VOTE_CHECKER_HALT_EN macro is defined)
//   - VOTE_WIDTH     : number of voter inputs
//   - VOTE_THRESHOLD : minimum number of asserted inputs for a 1 result
//   - VEC_CNT_W      : width of the accepted-vector counter (runs up to 65535)
//   - FAIL_VEC_W     : width of the captured {dut_out, vec_in} record
//   - majority()     : popcount(votes) >= VOTE_THRESHOLD
// -----------------------------------------------------------------------------
package vote_pkg;

    localparam int VOTE_WIDTH     = 5;
    localparam int VOTE_THRESHOLD = 3;
    localparam int VEC_CNT_W      = 16;
    localparam int FAIL_VEC_W     = VOTE_WIDTH + 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2,
        ST_HALT = 2'd3
    } vote_state_e;

    // Expected voter output: 1 when at least VOTE_THRESHOLD inputs are set.
    function automatic logic majority(input logic [VOTE_WIDTH-1:0] votes);
        logic [31:0] ones;
        ones = 32'd0;
        for (int i = 0; i < VOTE_WIDTH; i++) begin
            ones = ones + {31'd0, votes[i]};
        end
        return (ones >= 32'(VOTE_THRESHOLD));
    endfunction

endpackage

// File: rtl/vote_ref.sv
// -----------------------------------------------------------------------------
// vote_ref
// Combinational reference voter: produces the value a correct 3-of-5 majority
// voter must output for the given input vector.
// Ports:
//   i_votes    [VOTE_WIDTH-1:0]  voter inputs (bit0 = input 1)
//   o_expected                   1 when popcount(i_votes) >= VOTE_THRESHOLD
// -----------------------------------------------------------------------------
module vote_ref
    import vote_pkg::*;
(
    input  logic [VOTE_WIDTH-1:0] i_votes,
    output logic                  o_expected
);

    assign o_expected = majority(i_votes);

endmodule

// File: rtl/vote_checker.sv
// -----------------------------------------------------------------------------
// vote_checker
// Checks the observed output of an external 3-of-5 majority voter against a
// reference, over a run of NUM_VEC vectors, and reports pass/fail statistics.
//
// Parameters:
//   NUM_VEC  vectors checked per run (1..65535)
//   CNT_W    width of pass/fail counters (saturating)
//
// Ports:
//   clk          clock, all state updates on the rising edge
//   rst_n        synchronous active-low reset
//   start        one-cycle pulse, begins a run from IDLE/DONE (and HALT)
//   vec_valid    vec_in/dut_out carry a vector this cycle
//   vec_in       five voter inputs
//   dut_out      observed voter output for vec_in
//   vec_ready    checker accepts a vector this cycle
//   busy         run in progress (RUN or HALT)
//   done         run complete, held until the next start
//   err          sticky mismatch flag for the current run
//   pass_cnt     vectors matched this run
//   fail_cnt     vectors mismatched this run
//   fail_vec     first failing {dut_out, vec_in} of the run, 0 if none
//   o_dbg_state  current FSM state, for observation only
//
// Handshake: a vector transfers on a rising edge where vec_valid and
// vec_ready are both 1. vec_ready depends only on registered state, so the
// producer may hold vec_valid without waiting on a combinational loop.
//
// Configuration macro: VOTE_CHECKER_HALT_EN
//   defined   : the first mismatch stops the run in HALT until the next start
//   undefined : mismatches are counted and the run continues to NUM_VEC
// -----------------------------------------------------------------------------
module vote_checker
    import vote_pkg::*;
#(
    parameter int NUM_VEC = 10,
    parameter int CNT_W   = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic                  vec_valid,
    input  logic [VOTE_WIDTH-1:0] vec_in,
    input  logic                  dut_out,
    output logic                  vec_ready,
    output logic                  busy,
    output logic                  done,
    output logic                  err,
    output logic [CNT_W-1:0]      pass_cnt,
    output logic [CNT_W-1:0]      fail_cnt,
    output logic [FAIL_VEC_W-1:0] fail_vec,
    output vote_state_e           o_dbg_state
);

    localparam logic [VEC_CNT_W-1:0] LAST_CNT = VEC_CNT_W'(NUM_VEC);
    localparam logic [CNT_W-1:0]     CNT_MAX  = {CNT_W{1'b1}};

    vote_state_e               r_state;
    vote_state_e               w_state_nxt;

    logic [VEC_CNT_W-1:0]      r_acc_cnt;
    logic                      r_pend_valid;
    logic [VOTE_WIDTH-1:0]     r_pend_vec;
    logic                      r_pend_out;

    logic [CNT_W-1:0]          r_pass_cnt;
    logic [CNT_W-1:0]          r_fail_cnt;
    logic                      r_err;
    logic [FAIL_VEC_W-1:0]     r_fail_vec;

    logic                      w_expected;
    logic                      w_mismatch;
    logic                      w_all_accepted;
    logic                      w_ready;
    logic                      w_accept;
    logic                      w_run_clear;

    // -------------------------------------------------------------------------
    // Reference value for the registered (pending) vector
    // -------------------------------------------------------------------------
    vote_ref u_vote_ref (
        .i_votes    (r_pend_vec),
        .o_expected (w_expected)
    );

    assign w_mismatch     = r_pend_valid && (r_pend_out != w_expected);
    assign w_all_accepted = (r_acc_cnt == LAST_CNT);

    // A start is honoured everywhere except RUN; it wipes all run results.
    assign w_run_clear = start && (r_state != ST_RUN);

    always_comb begin
        w_ready = 1'b0;
        if (r_state == ST_RUN && !w_all_accepted) begin
            w_ready = 1'b1;
        end
`ifdef VOTE_CHECKER_HALT_EN
        // The cycle a mismatch is being counted is the cycle the FSM leaves
        // for HALT; refusing a vector here keeps the frozen counts exact.
        if (w_mismatch) begin
            w_ready = 1'b0;
        end
`endif
    end

    assign w_accept = vec_valid && w_ready;

    // -------------------------------------------------------------------------
    // FSM
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_state_nxt = ST_RUN;
                end
            end
            ST_RUN: begin
`ifdef VOTE_CHECKER_HALT_EN
                if (w_mismatch) begin
                    w_state_nxt = ST_HALT;
                end else
`endif
                // Once every vector is accepted, the last pending result is
                // counted on this same edge, so DONE never precedes it.
                if (w_all_accepted) begin
                    w_state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                if (start) begin
                    w_state_nxt = ST_RUN;
                end
            end
`ifdef VOTE_CHECKER_HALT_EN
            ST_HALT: begin
                if (start) begin
                    w_state_nxt = ST_RUN;
                end
            end
`endif
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Acceptance register, comparison and statistics
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_acc_cnt    <= '0;
            r_pend_valid <= 1'b0;
            r_pend_vec   <= '0;
            r_pend_out   <= 1'b0;
            r_pass_cnt   <= '0;
            r_fail_cnt   <= '0;
            r_err        <= 1'b0;
            r_fail_vec   <= '0;
        end else if (w_run_clear) begin
            r_acc_cnt    <= '0;
            r_pend_valid <= 1'b0;
            r_pend_vec   <= '0;
            r_pend_out   <= 1'b0;
            r_pass_cnt   <= '0;
            r_fail_cnt   <= '0;
            r_err        <= 1'b0;
            r_fail_vec   <= '0;
        end else begin
            r_pend_valid <= w_accept;
            if (w_accept) begin
                r_pend_vec <= vec_in;
                r_pend_out <= dut_out;
                r_acc_cnt  <= r_acc_cnt + VEC_CNT_W'(1);
            end

            if (r_pend_valid) begin
                if (w_mismatch) begin
                    if (r_fail_cnt != CNT_MAX) begin
                        r_fail_cnt <= r_fail_cnt + CNT_W'(1);
                    end
                    // err doubles as the "already captured" flag.
                    if (!r_err) begin
                        r_fail_vec <= {r_pend_out, r_pend_vec};
                    end
                    r_err <= 1'b1;
                end else begin
                    if (r_pass_cnt != CNT_MAX) begin
                        r_pass_cnt <= r_pass_cnt + CNT_W'(1);
                    end
                end
            end
        end
    end

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    assign vec_ready   = w_ready;
    assign busy        = (r_state == ST_RUN) || (r_state == ST_HALT);
    assign done        = (r_state == ST_DONE);
    assign err         = r_err;
    assign pass_cnt    = r_pass_cnt;
    assign fail_cnt    = r_fail_cnt;
    assign fail_vec    = r_fail_vec;
    assign o_dbg_state = r_state;

endmodule
